// File: rtl/mem_wb_fwd_hist_reg_pkg.sv
// mem_wb_fwd_hist_reg_pkg: shared constants and helpers for the MEM/WB writeback mux with history.
// Holds the default data width, the select-bit indices of both one-hot selects and
// the functions deriving the select widths from the history depth.
package mem_wb_fwd_hist_reg_pkg;

    localparam int DATA_W_DEF = 8;

    localparam int SEL_T_EXMEM     = 0;
    localparam int SEL_T_LD        = 1;
    localparam int SEL_T_HIST_BASE = 2;

    localparam int SEL_B_SFR       = 0;
    localparam int SEL_B_EXMEM     = 1;
    localparam int SEL_B_LD        = 2;
    localparam int SEL_B_HIST_BASE = 3;

    // Each history entry contributes two select bits (its top and bottom half).
    function automatic int sel_t_w(input int hist_depth);
        return SEL_T_HIST_BASE + 2 * hist_depth;
    endfunction

    function automatic int sel_b_w(input int hist_depth);
        return SEL_B_HIST_BASE + 2 * hist_depth;
    endfunction

endpackage

// File: rtl/mem_wb_fwd_hist_reg_onehot_mux.sv
// mem_wb_fwd_hist_reg_onehot_mux: N-input AND-OR mux with a one-hot check on the select.
// Ports: sel (N one-hot select bits), data_in (N packed words, input i at [i*DATA_W +: DATA_W]),
//        data_out (OR of all selected words), is_onehot (exactly one select bit set).
module mem_wb_fwd_hist_reg_onehot_mux #(
    parameter int N      = 2,
    parameter int DATA_W = 8
) (
    input  logic [N-1:0]        sel,
    input  logic [N*DATA_W-1:0] data_in,
    output logic [DATA_W-1:0]   data_out,
    output logic                is_onehot
);

    always_comb begin
        data_out = '0;
        for (int i = 0; i < N; i++)
            data_out = data_out | (data_in[i*DATA_W +: DATA_W] & {DATA_W{sel[i]}});
    end

    assign is_onehot = $onehot(sel);

endmodule

// File: rtl/mem_wb_fwd_hist_reg.sv
// mem_wb_fwd_hist_reg: registered MEM/WB writeback mux with an N-deep forwarding history.
// Ports: clock/reset_n (async active-low); in_valid, stall, flush control the stage;
//        sel_top/sel_bot one-hot selects over MEM-stage sources and history halves;
//        mem_wb_top/bot/valid is the MEM/WB register (= history entry 0);
//        hist_top_flat/hist_bot_flat expose all entries; sel_err is a sticky select error
//        cleared by sel_err_clr.
// Build option MEM_WB_SEL_CHK_EN: zero a half written with a non-one-hot select and
// enable sel_err; when undefined the raw OR-merge is written and sel_err is tied low.
module mem_wb_fwd_hist_reg
    import mem_wb_fwd_hist_reg_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int HIST_DEPTH = 2,
    parameter int SEL_T_W    = sel_t_w(HIST_DEPTH),
    parameter int SEL_B_W    = sel_b_w(HIST_DEPTH)
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         in_valid,
    input  logic                         stall,
    input  logic                         flush,
    input  logic [SEL_T_W-1:0]           sel_top,
    input  logic [SEL_B_W-1:0]           sel_bot,
    input  logic [DATA_W-1:0]            sfr_data,
    input  logic [DATA_W-1:0]            ex_mem_top,
    input  logic [DATA_W-1:0]            ex_mem_bot,
    input  logic [DATA_W-1:0]            ld_res_top,
    input  logic [DATA_W-1:0]            ld_res_bot,
    output logic [DATA_W-1:0]            mem_wb_top,
    output logic [DATA_W-1:0]            mem_wb_bot,
    output logic                         mem_wb_valid,
    output logic [DATA_W*HIST_DEPTH-1:0] hist_top_flat,
    output logic [DATA_W*HIST_DEPTH-1:0] hist_bot_flat,
    output logic                         sel_err,
    input  logic                         sel_err_clr
);

    logic [HIST_DEPTH-1:0][DATA_W-1:0] hist_top_q, hist_top_d;
    logic [HIST_DEPTH-1:0][DATA_W-1:0] hist_bot_q, hist_bot_d;
    logic                              valid_q, valid_d;
    logic [SEL_T_W-1:0][DATA_W-1:0]    top_src;
    logic [SEL_B_W-1:0][DATA_W-1:0]    bot_src;
    logic [DATA_W-1:0]                 top_mux, bot_mux, top_wr, bot_wr;
    logic                              top_ok, bot_ok, accept;

    // Mux sources read the pre-shift history so a write can forward from t and t-1.
    always_comb begin
        top_src                  = '0;
        bot_src                  = '0;
        top_src[SEL_T_EXMEM]     = ex_mem_top;
        top_src[SEL_T_LD]        = ld_res_top;
        bot_src[SEL_B_SFR]       = sfr_data;
        bot_src[SEL_B_EXMEM]     = ex_mem_bot;
        bot_src[SEL_B_LD]        = ld_res_bot;
        for (int k = 0; k < HIST_DEPTH; k++) begin
            top_src[SEL_T_HIST_BASE + 2*k]     = hist_top_q[k];
            top_src[SEL_T_HIST_BASE + 2*k + 1] = hist_bot_q[k];
            bot_src[SEL_B_HIST_BASE + 2*k]     = hist_top_q[k];
            bot_src[SEL_B_HIST_BASE + 2*k + 1] = hist_bot_q[k];
        end
    end

    mem_wb_fwd_hist_reg_onehot_mux #(.N(SEL_T_W), .DATA_W(DATA_W)) u_mux_top (
        .sel       (sel_top),
        .data_in   (top_src),
        .data_out  (top_mux),
        .is_onehot (top_ok)
    );

    mem_wb_fwd_hist_reg_onehot_mux #(.N(SEL_B_W), .DATA_W(DATA_W)) u_mux_bot (
        .sel       (sel_bot),
        .data_in   (bot_src),
        .data_out  (bot_mux),
        .is_onehot (bot_ok)
    );

    assign accept = in_valid & ~stall & ~flush;

`ifdef MEM_WB_SEL_CHK_EN
    logic sel_err_q, sel_err_d;

    assign top_wr = top_ok ? top_mux : '0;
    assign bot_wr = bot_ok ? bot_mux : '0;

    // A new error outranks a same-cycle clear; a stall without flush freezes the flag.
    always_comb begin
        sel_err_d = (stall & ~flush) ? sel_err_q
                  : (accept & ~(top_ok & bot_ok)) | (sel_err_q & ~sel_err_clr);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) sel_err_q <= 1'b0;
        else          sel_err_q <= sel_err_d;
    end

    assign sel_err = sel_err_q;
`else
    logic unused_sel_chk;

    assign top_wr         = top_mux;
    assign bot_wr         = bot_mux;
    assign sel_err        = 1'b0;
    assign unused_sel_chk = ^{top_ok, bot_ok, sel_err_clr};
`endif

    always_comb begin
        hist_top_d = hist_top_q;
        hist_bot_d = hist_bot_q;
        valid_d    = flush ? 1'b0 : stall ? valid_q : in_valid;
        if (accept) begin
            for (int k = 1; k < HIST_DEPTH; k++) begin
                hist_top_d[k] = hist_top_q[k-1];
                hist_bot_d[k] = hist_bot_q[k-1];
            end
            hist_top_d[0] = top_wr;
            hist_bot_d[0] = bot_wr;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hist_top_q <= '0;
            hist_bot_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            hist_top_q <= hist_top_d;
            hist_bot_q <= hist_bot_d;
            valid_q    <= valid_d;
        end
    end

    assign mem_wb_top    = hist_top_q[0];
    assign mem_wb_bot    = hist_bot_q[0];
    assign mem_wb_valid  = valid_q;
    assign hist_top_flat = hist_top_q;
    assign hist_bot_flat = hist_bot_q;

endmodule

// File: tb/tb_mem_wb_fwd_hist_reg.sv
// tb_mem_wb_fwd_hist_reg: directed self-checking bench for mem_wb_fwd_hist_reg (DATA_W=8, HIST_DEPTH=2).
module tb_mem_wb_fwd_hist_reg;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0, stall = 1'b0, flush = 1'b0, sel_err_clr = 1'b0;
    logic [5:0]  sel_top = '0;
    logic [6:0]  sel_bot = '0;
    logic [7:0]  sfr_data = '0, ex_mem_top = '0, ex_mem_bot = '0, ld_res_top = '0, ld_res_bot = '0;
    logic [7:0]  mem_wb_top, mem_wb_bot;
    logic        mem_wb_valid, sel_err;
    logic [15:0] hist_top_flat, hist_bot_flat;

    int n_cmp = 0;
    int n_bad = 0;

`ifdef MEM_WB_SEL_CHK_EN
    localparam logic [7:0] ERR_TOP = 8'h00;
    localparam logic       ERR_FLG = 1'b1;
`else
    localparam logic [7:0] ERR_TOP = 8'hFF;
    localparam logic       ERR_FLG = 1'b0;
`endif

    always #5 clock = ~clock;

    mem_wb_fwd_hist_reg #(.DATA_W(8), .HIST_DEPTH(2)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .in_valid      (in_valid),
        .stall         (stall),
        .flush         (flush),
        .sel_top       (sel_top),
        .sel_bot       (sel_bot),
        .sfr_data      (sfr_data),
        .ex_mem_top    (ex_mem_top),
        .ex_mem_bot    (ex_mem_bot),
        .ld_res_top    (ld_res_top),
        .ld_res_bot    (ld_res_bot),
        .mem_wb_top    (mem_wb_top),
        .mem_wb_bot    (mem_wb_bot),
        .mem_wb_valid  (mem_wb_valid),
        .hist_top_flat (hist_top_flat),
        .hist_bot_flat (hist_bot_flat),
        .sel_err       (sel_err),
        .sel_err_clr   (sel_err_clr)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_state(input string tag, input logic [7:0] t, input logic [7:0] b, input logic v,
                             input logic [15:0] ht, input logic [15:0] hb, input logic e);
        chk({tag, ".top"}, 32'(mem_wb_top), 32'(t));
        chk({tag, ".bot"}, 32'(mem_wb_bot), 32'(b));
        chk({tag, ".valid"}, 32'(mem_wb_valid), 32'(v));
        chk({tag, ".htop"}, 32'(hist_top_flat), 32'(ht));
        chk({tag, ".hbot"}, 32'(hist_bot_flat), 32'(hb));
        chk({tag, ".err"}, 32'(sel_err), 32'(e));
    endtask

    initial begin
        // reset held while a write is presented
        in_valid = 1'b1; sel_top = 6'b000001; sel_bot = 7'b0000010;
        ex_mem_top = 8'($urandom); ex_mem_bot = 8'($urandom);
        step(); step();
        chk_state("rst", 8'h00, 8'h00, 1'b0, 16'h0000, 16'h0000, 1'b0);
        reset_n = 1'b1; in_valid = 1'b0;
        step();
        chk_state("post_rst", 8'h00, 8'h00, 1'b0, 16'h0000, 16'h0000, 1'b0);

        // basic accept
        in_valid = 1'b1; sel_top = 6'b000001; sel_bot = 7'b0000001;
        ex_mem_top = 8'hA5; sfr_data = 8'h3C;
        step();
        chk_state("basic", 8'hA5, 8'h3C, 1'b1, 16'h00A5, 16'h003C, 1'b0);

        // history forwarding
        sel_bot = 7'b0000010; ex_mem_top = 8'h11; ex_mem_bot = 8'h22;
        step();
        ex_mem_top = 8'h33; ex_mem_bot = 8'h44;
        step();
        chk_state("hist_pre", 8'h33, 8'h44, 1'b1, 16'h1133, 16'h2244, 1'b0);
        sel_top = 6'b100000; sel_bot = 7'b0001000; ex_mem_top = 8'h77; ex_mem_bot = 8'h88;
        step();
        chk_state("fwd", 8'h22, 8'h33, 1'b1, 16'h3322, 16'h4433, 1'b0);

        // stall holds everything for three cycles
        stall = 1'b1; sel_top = 6'b000001; sel_bot = 7'b0000010; ex_mem_top = 8'h99; ex_mem_bot = 8'h66;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_state("stall", 8'h22, 8'h33, 1'b1, 16'h3322, 16'h4433, 1'b0);
        end
        // flush overrides stall
        flush = 1'b1;
        step();
        chk_state("flush", 8'h22, 8'h33, 1'b0, 16'h3322, 16'h4433, 1'b0);
        stall = 1'b0; flush = 1'b0;

        // multi-hot select
        sel_top = 6'b000011; ex_mem_top = 8'hF0; ld_res_top = 8'h0F;
        sel_bot = 7'b0000010; ex_mem_bot = 8'h55;
        step();
        chk_state("selerr", ERR_TOP, 8'h55, 1'b1, {8'h22, ERR_TOP}, 16'h3355, ERR_FLG);

        // bubble: valid drops, data and history hold, error stays sticky
        in_valid = 1'b0; sel_top = 6'b000001; ex_mem_top = 8'hEE;
        step();
        chk_state("bubble", ERR_TOP, 8'h55, 1'b0, {8'h22, ERR_TOP}, 16'h3355, ERR_FLG);
        step();
        chk("err_held", 32'(sel_err), 32'(ERR_FLG));
        sel_err_clr = 1'b1;
        step();
        sel_err_clr = 1'b0;
        chk_state("err_clr", ERR_TOP, 8'h55, 1'b0, {8'h22, ERR_TOP}, 16'h3355, 1'b0);

        // all-zero select on accept
        in_valid = 1'b1; sel_top = 6'b000001; sel_bot = 7'b0000000; ex_mem_top = 8'h5A;
        step();
        in_valid = 1'b0;
        chk_state("zero_sel", 8'h5A, 8'h00, 1'b1, {ERR_TOP, 8'h5A}, 16'h5500, ERR_FLG);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_wb_fwd_hist_reg.md
Name: mem_wb_fwd_hist_reg

Overview:
- Parametrised successor to the MEM/WB data input mux: same one-hot selection of writeback data, now with a registered MEM/WB stage and an N-deep writeback history.
- Sits between the MEM stage and the MEM/WB boundary.
- Registers the selected top/bottom bytes, maintains HIST_DEPTH past writebacks (t, t-1, …) as forwarding sources, and supports stall, flush and select-error detection.

Parameters:
- DATA_W, 8: width of each data half (top/bottom).
- HIST_DEPTH, 2: number of history entries. Entry 0 is the current MEM/WB register; entry k is the write k accepts earlier. Minimum 1.
- SEL_T_W, 2+2*HIST_DEPTH: top select width (derived, do not override).
- SEL_B_W, 3+2*HIST_DEPTH: bottom select width (derived, do not override).

Ports:
- clock  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  MEM stage presents a write this cycle
- stall  in  1  hold all state
- flush  in  1  kill current MEM/WB contents
- sel_top  in  SEL_T_W  one-hot top select: [0] ex_mem_top, [1] ld_res_top, [2+2k] hist[k].top, [3+2k] hist[k].bot
- sel_bot  in  SEL_B_W  one-hot bottom select: [0] sfr_data, [1] ex_mem_bot, [2] ld_res_bot, [3+2k] hist[k].top, [4+2k] hist[k].bot
- sfr_data  in  DATA_W  SFR read data
- ex_mem_top, ex_mem_bot  in  DATA_W each  EX/MEM data halves
- ld_res_top, ld_res_bot  in  DATA_W each  load results
- mem_wb_top, mem_wb_bot  out  DATA_W each  MEM/WB register (= hist[0])
- mem_wb_valid  out  1  MEM/WB holds a live write
- hist_top_flat, hist_bot_flat  out  DATA_W*HIST_DEPTH each  history; entry k at bits [k*DATA_W +: DATA_W]
- sel_err  out  1  sticky select error
- sel_err_clr  in  1  clears sel_err

Behaviour:
- Reset (async, reset_n=0): all history entries = 0, mem_wb_valid=0, sel_err=0. Outputs therefore reset to 0.
- Operations are resolved in priority order:
  1. flush
  2. stall
  3. accept = in_valid
  4. bubble
- flush=1:
  - mem_wb_valid <= 0.
  - History and data hold.
  - flush overrides stall and in_valid.
- stall=1 (no flush): every register holds, including mem_wb_valid.
- accept:
  - Shift history: hist[k] <= hist[k-1] for k≥1.
  - hist[0] <= muxed {top, bot}.
  - mem_wb_valid <= 1.
  - Latency is one cycle from inputs to mem_wb_*.
  - Muxing reads the pre-shift history, i.e. the values present before the clock edge.
- Bubble (in_valid=0, no stall, no flush): mem_wb_valid <= 0; data and history hold.
- Mux: AND-OR of each select bit with its source, bitwise across DATA_W.
- Selects are evaluated only on accept and are ignored otherwise.
- sel_err:
  - Set on accept when either select is not exactly one-hot (all-zero or multi-hot).
  - sel_err_clr clears it next cycle. A set and a clear in the same cycle resolves to set.
- HIST_DEPTH=1: only entry 0 exists; the t-1 selects are absent.

Optional Feature:
- MEM_WB_SEL_CHK_EN defined:
  - On a non-one-hot select at accept, the affected half is written as 0 instead of the AND-OR result.
  - sel_err operates as described above.
- Undefined:
  - Raw AND-OR result is written (legacy OR-merge behaviour).
  - sel_err is tied to 0 and sel_err_clr is ignored.

Decomposition:
- Shared package holds:
  - DATA_W default.
  - Select-bit index constants: SEL_T_EXMEM=0, SEL_T_LD=1, SEL_T_HIST_BASE=2, SEL_B_SFR=0, SEL_B_EXMEM=1, SEL_B_LD=2, SEL_B_HIST_BASE=3.
  - A function computing SEL widths from HIST_DEPTH.
- One sub-module: onehot_mux, parametrised by N inputs × DATA_W. It provides the AND-OR output plus an is_onehot flag and is instantiated twice (top, bottom).

Test Plan:
1. Reset: hold reset_n=0 with in_valid=1 and random data -> all outputs 0, mem_wb_valid=0; after release with no input, all outputs remain 0.
2. Basic accept: sel_top=0b000001, sel_bot=0b0000001, ex_mem_top=0xA5, sfr_data=0x3C, in_valid=1 -> next cycle mem_wb_top=0xA5, mem_wb_bot=0x3C, valid=1.
3. History forwarding (HIST_DEPTH=2):
   - Accept {0x11,0x22}, then {0x33,0x44}.
   - Third accept with sel_top bit5 (hist[1].bot) and sel_bot bit3 (hist[0].top) -> mem_wb_top=0x22, mem_wb_bot=0x33.
   - History afterwards: entry0={0x22,0x33}, entry1={0x33,0x44}.
4. Stall vs flush:
   - stall=1 with in_valid=1 and new data -> all state unchanged for 3 cycles.
   - stall=1 with flush=1 -> valid=0 next cycle, data unchanged.
5. Select error: sel_top=0b000011 with ex_mem_top=0xF0, ld_res_top=0x0F on accept.
   - With MEM_WB_SEL_CHK_EN: mem_wb_top=0x00, sel_err=1, held until sel_err_clr.
   - Without MEM_WB_SEL_CHK_EN: mem_wb_top=0xFF, sel_err=0.
6. Bubble: in_valid=0 after a valid write -> valid=0, mem_wb_top/bot and history unchanged.
